mpmc10_resv_tbl: RTL

Parametrised reservation table for LR/SC (load-reserved / store-conditional) support in the multi-port memory controller.
- Holds up to NAR line-granular reservations tagged by requesting channel.
- Reports store-conditional success one cycle after request.
- Invalidates reservations on conflicting writes from the request port or a write-snoop port, and ages out stale reservations.
- Sits beside the controller's port arbiter; the controller FSM presents one arbitrated request per cycle.

---
 rtl/mpmc10_resv_tbl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mpmc10_resv_tbl.sv
`default_nettype none
// ============================================================================
// Module      : mpmc10_resv_tbl
// Description : LR/SC reservation table for the multi-port memory controller.
//               Holds up to NAR line-granular reservations tagged by channel,
//               answers every request one clock later, drops reservations on
//               conflicting writes or snoops, and ages out stale entries.
// Revision    : 1.0  initial release
// ============================================================================
module mpmc10_resv_tbl #(
  parameter int NAR   = 4,
  parameter int NCH   = 8,
  parameter int AW    = 32,
  parameter int LGRAN = 4,
  parameter int RTO   = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [1:0]               req_op,
  input  logic [$clog2(NCH)-1:0]   req_ch,
  input  logic [AW-1:0]            req_adr,
  input  logic                     snp_valid,
  input  logic [AW-1:0]            snp_adr,
  output logic                     rsp_valid,
  output logic                     rsp_ok,
  output logic [$clog2(NAR+1)-1:0] resv_cnt
);

  localparam int CW   = $clog2(NCH);
  localparam int LW   = AW - LGRAN;
  localparam int AGW  = (RTO == 0) ? 1 : $clog2(RTO + 1);
  localparam int VW   = (NAR > 1) ? $clog2(NAR) : 1;
  localparam int CNTW = $clog2(NAR + 1);

  localparam logic [1:0]     OP_LR    = 2'd0;
  localparam logic [1:0]     OP_SC    = 2'd1;
  localparam logic [1:0]     OP_WR    = 2'd2;
  localparam logic [AGW-1:0] AGE_LAST = AGW'((RTO == 0) ? 0 : RTO - 1);

  logic [NAR-1:0]  vld_q, vld_d;
  logic [CW-1:0]   ch_q   [NAR];
  logic [CW-1:0]   ch_d   [NAR];
  logic [LW-1:0]   line_q [NAR];
  logic [LW-1:0]   line_d [NAR];
  logic [AGW-1:0]  age_q  [NAR];
  logic [AGW-1:0]  age_d  [NAR];
  logic [VW-1:0]   vic_q, vic_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_ok_q, rsp_ok_d;
  logic [CNTW-1:0] resv_cnt_q, resv_cnt_d;

  logic [LW-1:0]   req_line;
  logic [LW-1:0]   snp_line;
  logic            ch_ok;
  logic [NAR-1:0]  vld_pc;
  logic            own_hit, free_hit, sc_ok;
  int              own_idx, free_idx;

  // Sub-granule address bits never take part in a compare.
  logic unused_lo_bits;
  assign unused_lo_bits = ^{req_adr[LGRAN-1:0], snp_adr[LGRAN-1:0]};

  assign req_line = req_adr[AW-1:LGRAN];
  assign snp_line = snp_adr[AW-1:LGRAN];
  assign ch_ok    = (32'(req_ch) < 32'(NCH));

  // Next table state: ageing, then snoop clears, then the request effect.
  always_comb begin
    vld_pc     = vld_q;
    ch_d       = ch_q;
    line_d     = line_q;
    age_d      = age_q;
    vic_d      = vic_q;
    own_hit    = 1'b0;
    own_idx    = 0;
    free_hit   = 1'b0;
    free_idx   = 0;
    resv_cnt_d = '0;

    for (int i = 0; i < NAR; i++) begin
      if (vld_q[i]) begin
        age_d[i] = age_q[i] + AGW'(1);
        if (RTO != 0 && age_q[i] == AGE_LAST) vld_pc[i] = 1'b0;
      end
      if (snp_valid && line_q[i] == snp_line) vld_pc[i] = 1'b0;
    end

    // Owner and free-slot lookups see the table after ageing and snoop.
    for (int i = NAR - 1; i >= 0; i--) begin
      if (vld_pc[i] && ch_q[i] == req_ch) begin
        own_hit = 1'b1;
        own_idx = i;
      end
      if (!vld_pc[i]) begin
        free_hit = 1'b1;
        free_idx = i;
      end
    end
    sc_ok = own_hit && (line_q[own_idx] == req_line);

    vld_d = vld_pc;
    if (req_valid && ch_ok) begin
      case (req_op)
        OP_LR: begin
          if (own_hit) begin
            line_d[own_idx] = req_line;
            age_d[own_idx]  = '0;
          end else if (free_hit) begin
            vld_d[free_idx]  = 1'b1;
            ch_d[free_idx]   = req_ch;
            line_d[free_idx] = req_line;
            age_d[free_idx]  = '0;
          end else begin
            vld_d[vic_q]  = 1'b1;
            ch_d[vic_q]   = req_ch;
            line_d[vic_q] = req_line;
            age_d[vic_q]  = '0;
            vic_d = (vic_q == VW'(NAR - 1)) ? '0 : vic_q + VW'(1);
          end
        end
        OP_SC: begin
          if (own_hit) vld_d[own_idx] = 1'b0;
          if (sc_ok) begin
            for (int i = 0; i < NAR; i++)
              if (line_q[i] == req_line) vld_d[i] = 1'b0;
          end
        end
        OP_WR: begin
          for (int i = 0; i < NAR; i++)
            if (line_q[i] == req_line) vld_d[i] = 1'b0;
        end
        default: begin
          if (own_hit) vld_d[own_idx] = 1'b0;
        end
      endcase
    end

    for (int i = 0; i < NAR; i++) resv_cnt_d = resv_cnt_d + CNTW'(vld_d[i]);

    rsp_valid_d = req_valid;
    rsp_ok_d    = req_valid && ch_ok &&
                  ((req_op == OP_LR) || (req_op == OP_SC && sc_ok));
  end

  // Table, victim pointer and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      vic_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
      resv_cnt_q  <= '0;
      for (int i = 0; i < NAR; i++) begin
        ch_q[i]   <= '0;
        line_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      vld_q       <= vld_d;
      vic_q       <= vic_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ok_q    <= rsp_ok_d;
      resv_cnt_q  <= resv_cnt_d;
      for (int i = 0; i < NAR; i++) begin
        ch_q[i]   <= ch_d[i];
        line_q[i] <= line_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_ok    = rsp_ok_q;
  assign resv_cnt  = resv_cnt_q;

endmodule
`default_nettype wire
